fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction-cycle controller for the ternary core. Owns the ternary program counter and drives the fetch stage's fetch_enable.
- Latches the fetched instruction and sequences FETCH -> DECODE -> EXECUTE, with branch redirect, halt, and fault detection.
- Sits between instruction memory / fetch passthrough and the decode/execute units.

Parameters:
- WORD_SIZE, 9, trits per word; instructions are 2*WORD_SIZE bits, 2 bits per trit.
- ADDR_TRITS, 9, trits in the program counter; pc is 2*ADDR_TRITS bits.
- RESET_PC, all-zero (value 0), pc value loaded on reset.
- FETCH_TIMEOUT, 15, maximum cycles spent in FETCH without mem_ready before a timeout fault.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE (or resume from HALT) and begin fetching.
- mem_ready  in  1  instruction_memory is valid this cycle.
- instruction_memory  in  2*WORD_SIZE  instruction word from memory/fetch stage.
- exec_done  in  1  execute unit finished the current instruction.
- halt_instr  in  1  current instruction is HALT; qualified by exec_done.
- branch_taken  in  1  redirect pc; qualified by exec_done.
- branch_target  in  2*ADDR_TRITS  redirect address.
- pc  out  2*ADDR_TRITS  current instruction address.
- fetch_enable  out  1  high in FETCH only.
- instruction  out  2*WORD_SIZE  latched instruction register.
- decode_enable  out  1  one-cycle pulse in DECODE.
- execute_enable  out  1  high throughout EXECUTE.
- halted  out  1  high in HALT.
- fault_code  out  2  00 none, 01 illegal trit in instruction, 10 fetch timeout, 11 illegal trit in branch target.

Behaviour:
- Trit encoding: 00=0, 01=+1, 10=-1, 11=illegal.
- Reset (wins over all inputs, any state, mid-operation included): state IDLE, pc=RESET_PC, instruction=0, fault_code=00, wait counter=0, and all enables and halted low.
- fetch_enable, decode_enable, execute_enable and halted are Moore outputs decoded from state.
- IDLE: start -> FETCH next cycle.
- FETCH:
  - Counter increments each cycle without mem_ready.
  - mem_ready: instruction <= instruction_memory.
    - If any trit is 11 -> FAULT with code 01.
    - Otherwise -> DECODE.
  - mem_ready is accepted in the same cycle fetch_enable rises, so minimum FETCH is 1 cycle.
  - Counter reaching FETCH_TIMEOUT with mem_ready low -> FAULT with code 10.
  - mem_ready on the timeout cycle counts as success.
  - Counter clears on leaving FETCH.
- DECODE: exactly 1 cycle -> EXECUTE.
- EXECUTE: hold until exec_done.
  - On exec_done, priority is halt_instr > branch_taken > sequential.
  - halt_instr: pc unchanged -> HALT.
  - branch_taken:
    - If branch_target contains 11 -> FAULT with code 11, pc unchanged.
    - Otherwise pc <= branch_target -> FETCH.
  - Else pc <= pc+1 (balanced ternary) -> FETCH.
- Balanced-ternary increment:
  - Scan from LS trit: 0 -> +1 stop; -1 -> 0 stop; +1 -> -1 with carry.
  - Wrap: all +1 (max) -> all -1 (min), no flag.
- Minimum instruction cycle is 3 clocks (FETCH, DECODE, EXECUTE).
- HALT: halted=1; start -> FETCH at current pc, which is still the HALT address.
- FAULT: fault_code held; absorbing state, exits only on reset. No enables are asserted.
- Inputs outside their qualifying state are ignored (mem_ready outside FETCH, exec_done outside EXECUTE, start outside IDLE/HALT).

Test Plan (WORD_SIZE=9, ADDR_TRITS=3, FETCH_TIMEOUT=4):
- Reset, then start; mem_ready tied 1, exec_done tied 1, no branch.
  - fetch_enable/decode_enable/execute_enable rotate every 3 cycles.
  - pc goes 000000 -> 000001 -> 000110 (+2) -> 000100 (+3).
- Set pc to 010101 (+13) via a branch, then complete one sequential instruction -> pc becomes 101010 (-13), no fault.
- instruction_memory with trit0=11 on mem_ready -> FAULT, fault_code=01, all enables low for 10+ cycles. Then reset -> IDLE, pc=000000, fault_code=00.
- Hold mem_ready low in FETCH -> fault_code=10 after 4 cycles. Repeat with mem_ready high on cycle 4 -> DECODE, no fault.
- exec_done with halt_instr=1 and branch_taken=1 at pc=000001 -> halted=1, pc stays 000001. Then start -> FETCH with pc=000001.
- Two branch cases:
  - exec_done, branch_taken, target 100100 -> next FETCH with pc=100100.
  - Target 110000 -> fault_code=11.
- Assert reset mid-EXECUTE -> next cycle IDLE, all outputs at reset values.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction-cycle controller for the ternary core. Owns the
//                balanced-ternary program counter and sequences
//                FETCH -> DECODE -> EXECUTE with branch redirect, halt and
//                fault detection (illegal trits, fetch timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int                        WORD_SIZE     = 9,
    parameter int                        ADDR_TRITS    = 9,
    parameter logic [2*ADDR_TRITS-1:0]   RESET_PC      = '0,
    parameter int                        FETCH_TIMEOUT = 15
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         mem_ready,
    input  logic [2*WORD_SIZE-1:0]       instruction_memory,
    input  logic                         exec_done,
    input  logic                         halt_instr,
    input  logic                         branch_taken,
    input  logic [2*ADDR_TRITS-1:0]      branch_target,
    output logic [2*ADDR_TRITS-1:0]      pc,
    output logic                         fetch_enable,
    output logic [2*WORD_SIZE-1:0]       instruction,
    output logic                         decode_enable,
    output logic                         execute_enable,
    output logic                         halted,
    output logic [1:0]                   fault_code
);

    localparam int c_iw    = 2 * WORD_SIZE;
    localparam int c_aw    = 2 * ADDR_TRITS;
    localparam int c_cnt_w = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;

    // Last counter value before a missing mem_ready turns into a timeout.
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FETCH_TIMEOUT - 1);

    // Low bit of every trit; ANDing a word with itself shifted right by one
    // and masking with this leaves a 1 exactly where a trit is 2'b11.
    localparam logic [c_iw-1:0] c_instr_lo = {WORD_SIZE{2'b01}};
    localparam logic [c_aw-1:0] c_addr_lo  = {ADDR_TRITS{2'b01}};

    localparam logic [1:0] c_fault_none   = 2'b00;
    localparam logic [1:0] c_fault_instr  = 2'b01;
    localparam logic [1:0] c_fault_tmo    = 2'b10;
    localparam logic [1:0] c_fault_target = 2'b11;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_fetch   = 3'd1;
    localparam logic [2:0] c_st_decode  = 3'd2;
    localparam logic [2:0] c_st_execute = 3'd3;
    localparam logic [2:0] c_st_halt    = 3'd4;
    localparam logic [2:0] c_st_fault   = 3'd5;

    logic [2:0]          r_state;
    logic [c_aw-1:0]     r_pc;
    logic [c_iw-1:0]     r_instr;
    logic [1:0]          r_fault;
    logic [c_cnt_w-1:0]  r_wait_cnt;

    logic                w_instr_bad;
    logic                w_target_bad;
    logic [c_aw-1:0]     w_pc_next;

    // Balanced-ternary +1: walk up from the LS trit, +1 rolls to -1 with carry.
    // The all-(+1) word therefore wraps to all-(-1) with no flag.
    function automatic logic [c_aw-1:0] bt_inc(input logic [c_aw-1:0] v);
        logic [c_aw-1:0] res;
        logic            carry;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < ADDR_TRITS; i++) begin
            if (carry) begin
                case (v[2*i +: 2])
                    2'b00: begin res[2*i +: 2] = 2'b01; carry = 1'b0; end
                    2'b10: begin res[2*i +: 2] = 2'b00; carry = 1'b0; end
                    2'b01: begin res[2*i +: 2] = 2'b10; carry = 1'b1; end
                    default: carry = 1'b0;  // unreachable: pc never holds 11
                endcase
            end
        end
        return res;
    endfunction

    // Illegal-trit detection and next sequential address.
    assign w_instr_bad  = |(instruction_memory & (instruction_memory >> 1) & c_instr_lo);
    assign w_target_bad = |(branch_target & (branch_target >> 1) & c_addr_lo);
    assign w_pc_next    = bt_inc(r_pc);

    // Instruction-cycle state machine with pc, instruction and fault registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_fault    <= c_fault_none;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) r_state <= c_st_fetch;
                end
                c_st_fetch: begin
                    if (mem_ready) begin
                        // A ready on the timeout cycle still counts as a fetch.
                        r_instr    <= instruction_memory;
                        r_wait_cnt <= '0;
                        if (w_instr_bad) begin
                            r_fault <= c_fault_instr;
                            r_state <= c_st_fault;
                        end else begin
                            r_state <= c_st_decode;
                        end
                    end else if (r_wait_cnt == c_cnt_last) begin
                        r_wait_cnt <= '0;
                        r_fault    <= c_fault_tmo;
                        r_state    <= c_st_fault;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
                    end
                end
                c_st_decode: begin
                    r_state <= c_st_execute;
                end
                c_st_execute: begin
                    if (exec_done) begin
                        if (halt_instr) begin
                            r_state <= c_st_halt;
                        end else if (branch_taken) begin
                            if (w_target_bad) begin
                                r_fault <= c_fault_target;
                                r_state <= c_st_fault;
                            end else begin
                                r_pc    <= branch_target;
                                r_state <= c_st_fetch;
                            end
                        end else begin
                            r_pc    <= w_pc_next;
                            r_state <= c_st_fetch;
                        end
                    end
                end
                c_st_halt: begin
                    // Resume re-fetches the HALT address itself.
                    if (start) r_state <= c_st_fetch;
                end
                c_st_fault: begin
                    r_state <= c_st_fault;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from the state register.
    assign fetch_enable   = (r_state == c_st_fetch);
    assign decode_enable  = (r_state == c_st_decode);
    assign execute_enable = (r_state == c_st_execute);
    assign halted         = (r_state == c_st_halt);
    assign pc             = r_pc;
    assign instruction    = r_instr;
    assign fault_code     = r_fault;

endmodule
`default_nettype wire
